// File: rtl/mandel_pkg.sv
// Shared types and defaults for the Mandelbrot iteration scheduler.
package mandel_pkg;

    // Control states of the per-pixel iteration sequencer.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        CALC  = 3'd2,
        CHECK = 3'd3,
        EMIT  = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam int DEF_STAGES = 2;
    localparam int DEF_ITER_W = 16;
    localparam int DEF_H_RES  = 640;
    localparam int DEF_V_RES  = 480;
    localparam int DEF_X_W    = 10;
    localparam int DEF_Y_W    = 9;

    // Width of an index register able to address n items (at least one bit).
    function automatic int idx_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster walker: column/row position of the pixel being computed, advanced
// once per transferred result and wrapped to (0,0) after the final pixel.
module raster_counter
    import mandel_pkg::*;
#(
    parameter int H_RES = DEF_H_RES,
    parameter int V_RES = DEF_V_RES,
    parameter int X_W   = DEF_X_W,
    parameter int Y_W   = DEF_Y_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           advance_i,
    output logic [X_W-1:0] pix_x_o,
    output logic [Y_W-1:0] pix_y_o,
    output logic           last_o
);

    localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           at_eol_s;
    logic           at_last_s;

    assign at_eol_s  = (x_q == X_LAST);
    assign at_last_s = at_eol_s && (y_q == Y_LAST);

    // Next raster position: step right, wrap to the next line, or wrap the frame.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (advance_i) begin
            if (at_last_s) begin
                x_d = {X_W{1'b0}};
                y_d = {Y_W{1'b0}};
            end else if (at_eol_s) begin
                x_d = {X_W{1'b0}};
                y_d = y_q + Y_W'(1);
            end else begin
                x_d = x_q + X_W'(1);
                y_d = y_q;
            end
        end else begin
            x_d = x_q;
            y_d = y_q;
        end
    end

    // Position registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= {X_W{1'b0}};
            y_q <= {Y_W{1'b0}};
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign pix_x_o = x_q;
    assign pix_y_o = y_q;
    assign last_o  = at_last_s;

endmodule

// File: rtl/mandel_iter_sched.sv
// Control sequencer for one Mandelbrot iteration datapath: steps the
// pipeline stages, counts iterations, decides escape/limit and hands one
// result per pixel to the output queue while walking a whole frame.
module mandel_iter_sched
    import mandel_pkg::*;
#(
    parameter int STAGES = DEF_STAGES,
    parameter int ITER_W = DEF_ITER_W,
    parameter int H_RES  = DEF_H_RES,
    parameter int V_RES  = DEF_V_RES,
    parameter int X_W    = DEF_X_W,
    parameter int Y_W    = DEF_Y_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ITER_W-1:0] max_iter,
    input  logic              escaped,
    input  logic              queue_full,
    output logic              init,
    output logic              en_pixel_map,
    output logic [STAGES-1:0] en_stage,
    output logic [X_W-1:0]    pix_x,
    output logic [Y_W-1:0]    pix_y,
    output logic              res_valid,
    output logic [ITER_W-1:0] res_iter,
    output logic              res_escaped,
    output logic              res_last,
    output logic              busy,
    output logic              frame_done
);

    localparam int              SI_W       = idx_width(STAGES);
    localparam logic [SI_W-1:0] LAST_STAGE = SI_W'(STAGES - 1);

    state_t              state_q, state_d;
    logic [SI_W-1:0]     stage_idx_q, stage_idx_d;
    logic [ITER_W-1:0]   iter_cnt_q, iter_cnt_d;
    logic [ITER_W-1:0]   max_lat_q, max_lat_d;
    logic [ITER_W-1:0]   res_iter_q, res_iter_d;
    logic                res_escaped_q, res_escaped_d;
    logic                res_last_q, res_last_d;
    logic [STAGES-1:0]   en_stage_q, en_stage_d;
    logic                init_q;
    logic                en_map_q;
    logic                res_valid_q;
    logic                busy_q;
    logic                frame_done_q;

    logic [ITER_W-1:0]   iter_inc_s;
    logic                limit_hit_s;
    logic                transfer_s;
    logic                raster_last_s;

    // iter_cnt stays below max_lat, so the increment cannot wrap.
    assign iter_inc_s  = iter_cnt_q + ITER_W'(1);
    assign limit_hit_s = (iter_inc_s == max_lat_q);
    assign transfer_s  = (state_q == EMIT) && !queue_full;

    raster_counter #(
        .H_RES (H_RES),
        .V_RES (V_RES),
        .X_W   (X_W),
        .Y_W   (Y_W)
    ) u_raster (
        .clk       (clk),
        .rst_n     (rst_n),
        .advance_i (transfer_s),
        .pix_x_o   (pix_x),
        .pix_y_o   (pix_y),
        .last_o    (raster_last_s)
    );

    // Next state plus stage index, iteration count, limit latch and result capture.
    always_comb begin
        state_d       = state_q;
        stage_idx_d   = stage_idx_q;
        iter_cnt_d    = iter_cnt_q;
        max_lat_d     = max_lat_q;
        res_iter_d    = res_iter_q;
        res_escaped_d = res_escaped_q;
        res_last_d    = res_last_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // A zero limit would never terminate; run one iteration instead.
                    max_lat_d = (max_iter == ITER_W'(0)) ? ITER_W'(1) : max_iter;
                    state_d   = INIT;
                end else begin
                    state_d = IDLE;
                end
            end
            INIT: begin
                iter_cnt_d  = ITER_W'(0);
                stage_idx_d = SI_W'(0);
                state_d     = CALC;
            end
            CALC: begin
                if (stage_idx_q == LAST_STAGE) begin
                    state_d = CHECK;
                end else begin
                    stage_idx_d = stage_idx_q + SI_W'(1);
                    state_d     = CALC;
                end
            end
            CHECK: begin
                iter_cnt_d = iter_inc_s;
                if (escaped || limit_hit_s) begin
                    // Escape wins when it coincides with the limit.
                    res_iter_d    = iter_inc_s;
                    res_escaped_d = escaped;
                    res_last_d    = raster_last_s;
                    state_d       = EMIT;
                end else begin
                    stage_idx_d = SI_W'(0);
                    state_d     = CALC;
                end
            end
            EMIT: begin
                if (!queue_full) begin
                    state_d = raster_last_s ? DONE : INIT;
                end else begin
                    state_d = EMIT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // One-hot stage enable for the coming cycle, decoded from the next stage index.
    always_comb begin
        en_stage_d = {STAGES{1'b0}};
        for (int i = 0; i < STAGES; i++) begin
            if (state_d == CALC) begin
                en_stage_d[i] = (stage_idx_d == SI_W'(i));
            end else begin
                en_stage_d[i] = 1'b0;
            end
        end
    end

    // State, counters and output registers; outputs are decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            stage_idx_q   <= SI_W'(0);
            iter_cnt_q    <= ITER_W'(0);
            max_lat_q     <= ITER_W'(0);
            res_iter_q    <= ITER_W'(0);
            res_escaped_q <= 1'b0;
            res_last_q    <= 1'b0;
            en_stage_q    <= {STAGES{1'b0}};
            init_q        <= 1'b0;
            en_map_q      <= 1'b0;
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            stage_idx_q   <= stage_idx_d;
            iter_cnt_q    <= iter_cnt_d;
            max_lat_q     <= max_lat_d;
            res_iter_q    <= res_iter_d;
            res_escaped_q <= res_escaped_d;
            res_last_q    <= res_last_d;
            en_stage_q    <= en_stage_d;
            init_q        <= (state_d == INIT);
            en_map_q      <= (state_d == INIT);
            res_valid_q   <= (state_d == EMIT);
            busy_q        <= (state_d != IDLE);
            frame_done_q  <= (state_d == DONE);
        end
    end

    assign init         = init_q;
    assign en_pixel_map = en_map_q;
    assign en_stage     = en_stage_q;
    assign res_valid    = res_valid_q;
    assign res_iter     = res_iter_q;
    assign res_escaped  = res_escaped_q;
    assign res_last     = res_last_q;
    assign busy         = busy_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_mandel_iter_sched.sv
// Bench for mandel_iter_sched: two small instances (STAGES=2 on a 4x2 raster,
// STAGES=1 on a 3x2 raster) driven through table frames, random frames,
// queue stalls, ignored starts and an asynchronous mid-frame reset.
module tb_mandel_iter_sched;

    localparam int IW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start;
    logic [IW-1:0] max_iter;
    logic          escaped;
    logic          queue_full;
    int            sel;
    logic          start_a, start_b;

    logic          a_init, a_map, a_v, a_esc, a_last, a_busy, a_done;
    logic [1:0]    a_en;
    logic [1:0]    a_x;
    logic [0:0]    a_y;
    logic [IW-1:0] a_it;
    logic          b_init, b_map, b_v, b_esc, b_last, b_busy, b_done;
    logic [0:0]    b_en;
    logic [1:0]    b_x;
    logic [0:0]    b_y;
    logic [IW-1:0] b_it;

    logic          cur_init, cur_map, cur_v, cur_esc, cur_last, cur_busy, cur_done;
    logic [1:0]    cur_en;
    logic [1:0]    cur_x;
    logic [0:0]    cur_y;
    logic [IW-1:0] cur_it;

    assign start_a = start && (sel == 0);
    assign start_b = start && (sel == 1);

    mandel_iter_sched #(.STAGES(2), .ITER_W(IW), .H_RES(4), .V_RES(2), .X_W(2), .Y_W(1)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .max_iter(max_iter), .escaped(escaped),
        .queue_full(queue_full), .init(a_init), .en_pixel_map(a_map), .en_stage(a_en),
        .pix_x(a_x), .pix_y(a_y), .res_valid(a_v), .res_iter(a_it), .res_escaped(a_esc),
        .res_last(a_last), .busy(a_busy), .frame_done(a_done));

    mandel_iter_sched #(.STAGES(1), .ITER_W(IW), .H_RES(3), .V_RES(2), .X_W(2), .Y_W(1)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .max_iter(max_iter), .escaped(escaped),
        .queue_full(queue_full), .init(b_init), .en_pixel_map(b_map), .en_stage(b_en),
        .pix_x(b_x), .pix_y(b_y), .res_valid(b_v), .res_iter(b_it), .res_escaped(b_esc),
        .res_last(b_last), .busy(b_busy), .frame_done(b_done));

    // Observe whichever instance is currently under test.
    always_comb begin
        cur_init = (sel == 1) ? b_init : a_init;
        cur_map  = (sel == 1) ? b_map  : a_map;
        cur_en   = (sel == 1) ? {1'b0, b_en} : a_en;
        cur_x    = (sel == 1) ? b_x    : a_x;
        cur_y    = (sel == 1) ? b_y    : a_y;
        cur_v    = (sel == 1) ? b_v    : a_v;
        cur_it   = (sel == 1) ? b_it   : a_it;
        cur_esc  = (sel == 1) ? b_esc  : a_esc;
        cur_last = (sel == 1) ? b_last : a_last;
        cur_busy = (sel == 1) ? b_busy : a_busy;
        cur_done = (sel == 1) ? b_done : a_done;
    end

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string name, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t sel=%0d)", name, act, exp, $time, sel);
        end
    endtask

    task automatic chk_zero(input string name);
        chk(name, int'({cur_init, cur_map, cur_en, cur_x, cur_y, cur_v, cur_it,
                        cur_esc, cur_last, cur_busy, cur_done}), 0);
    endtask

    // Reference: result of one pixel given the limit and the iteration whose CHECK sees escape.
    function automatic void model(input int mi, input int ea, output int it, output int es);
        int lat;
        lat = (mi == 0) ? 1 : mi;
        if (ea >= 1 && ea <= lat) begin
            it = ea;
            es = 1;
        end else begin
            it = lat;
            es = 0;
        end
    endfunction

    int esc_at [8];
    int ex_it  [8];
    int ex_es  [8];

    // One frame. esc_fixed<0 picks a random escape point per pixel and uses the model;
    // otherwise every pixel uses the given escape point and the given expectations.
    // qmode: 0 never full, 1 random full, 2 full for the first 4 EMIT cycles of pixel 0.
    task automatic run_frame(input int mi, input int esc_fixed, input int fx_it,
                             input int fx_es, input int qmode);
        int  npix, hres, ns, pi, iter_seen, init_cyc, vcnt, dones, rel, ph, expen;
        bit  prev_last, fin, qf;
        npix = (sel == 0) ? 8 : 6;
        hres = (sel == 0) ? 4 : 3;
        ns   = (sel == 0) ? 2 : 1;
        for (int p = 0; p < npix; p++) begin
            if (esc_fixed >= 0) begin
                esc_at[p] = esc_fixed;
                ex_it[p]  = fx_it;
                ex_es[p]  = fx_es;
            end else begin
                esc_at[p] = int'($urandom_range(0, mi + 1));
                model(mi, esc_at[p], ex_it[p], ex_es[p]);
            end
        end
        @(negedge clk);
        chk("idle_before_start", int'(cur_busy), 0);
        start    = 1'b1;
        max_iter = IW'(mi);
        @(negedge clk);
        chk("start_accepted", int'(cur_busy), 1);
        max_iter = IW'($urandom);
        pi = 0; iter_seen = 0; init_cyc = 0; vcnt = 0; dones = 0;
        prev_last = 1'b0; fin = 1'b0;
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            if (cyc > 0) @(negedge clk);
            start = (pi < npix) ? 1'($urandom) : 1'b0;
            if (prev_last) begin
                escaped = (pi < npix) ? (iter_seen == esc_at[pi]) : 1'b0;
            end else begin
                escaped = 1'($urandom);
            end
            prev_last = cur_en[ns-1];
            if (prev_last) iter_seen++;
            if (cur_init) begin
                chk("en_pixel_map", int'(cur_map), 1);
                chk("pix_x_at_init", int'(cur_x), pi % hres);
                chk("pix_y_at_init", int'(cur_y), pi / hres);
                init_cyc  = cyc;
                iter_seen = 0;
                vcnt      = 0;
                queue_full = 1'($urandom);
            end else if (cur_v) begin
                if (pi >= npix) begin
                    chk("extra_result", 1, 0);
                    queue_full = 1'b0;
                end else begin
                    if (vcnt == 0) chk("latency", cyc - init_cyc, 1 + ex_it[pi] * (ns + 1));
                    chk("res_iter", int'(cur_it), ex_it[pi]);
                    chk("res_escaped", int'(cur_esc), ex_es[pi]);
                    chk("res_pix_x", int'(cur_x), pi % hres);
                    chk("res_pix_y", int'(cur_y), pi / hres);
                    chk("res_last", int'(cur_last), (pi == npix - 1) ? 1 : 0);
                    chk("emit_no_enable", int'(cur_en), 0);
                    vcnt++;
                    if (qmode == 2 && pi == 0) qf = (vcnt <= 4);
                    else if (qmode == 1)       qf = ($urandom_range(0, 2) == 0);
                    else                       qf = 1'b0;
                    queue_full = qf;
                    if (!qf) pi++;
                end
            end else if (cur_done) begin
                chk("done_after_all_results", pi, npix);
                dones++;
                start = 1'b1;
                fin   = 1'b1;
            end else begin
                queue_full = 1'($urandom);
                if (pi >= npix) begin
                    chk("frame_done_late", 0, 1);
                end else begin
                    chk("busy_in_frame", int'(cur_busy), 1);
                    rel   = cyc - init_cyc;
                    ph    = (rel - 1) % (ns + 1);
                    expen = (ph < ns) ? (1 << ph) : 0;
                    chk("en_stage", int'(cur_en), expen);
                end
            end
        end
        chk("frame_finished", int'(fin), 1);
        @(negedge clk);
        start   = 1'b0;
        escaped = 1'b0;
        chk("busy_after_done", int'(cur_busy), 0);
        chk("done_one_pulse", int'(cur_done), 0);
        chk("start_in_done_ignored", int'(cur_init), 0);
        chk("done_count", dones, 1);
    endtask

    typedef struct {
        int mi;
        int esc_at;
        int exp_iter;
        int exp_esc;
    } vec_t;

    vec_t tbl [8];
    bit   found;

    initial begin
        tbl[0] = '{5, 0, 5, 0};
        tbl[1] = '{5, 3, 3, 1};
        tbl[2] = '{0, 0, 1, 0};
        tbl[3] = '{1, 0, 1, 0};
        tbl[4] = '{4, 4, 4, 1};
        tbl[5] = '{3, 7, 3, 0};
        tbl[6] = '{2, 1, 1, 1};
        tbl[7] = '{1, 1, 1, 1};

        rst_n = 1'b0; start = 1'b0; max_iter = IW'(0);
        escaped = 1'b0; queue_full = 1'b0; sel = 0;
        repeat (2) @(negedge clk);
        chk_zero("reset_outputs_a");
        sel = 1;
        #1 chk_zero("reset_outputs_b");
        sel = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("idle_after_release");

        for (int i = 0; i < 8; i++) begin
            run_frame(tbl[i].mi, tbl[i].esc_at, tbl[i].exp_iter, tbl[i].exp_esc, 0);
        end

        run_frame(5, 0, 5, 0, 2);

        for (int i = 0; i < 6; i++) begin
            run_frame(int'($urandom_range(0, 6)), -1, 0, 0, 1);
        end

        // Abort in the middle of pixel 1's CALC phase.
        @(negedge clk);
        start = 1'b1; max_iter = IW'(5); escaped = 1'b0; queue_full = 1'b0;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (cur_x == 2'd1 && cur_en != 2'd0) found = 1'b1;
        end
        chk("reach_mid_calc", int'(found), 1);
        rst_n = 1'b0;
        #1 chk_zero("async_reset_abort");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("idle_after_abort");
        run_frame(3, 2, 2, 1, 0);

        sel = 1;
        for (int i = 0; i < 8; i++) begin
            run_frame(tbl[i].mi, tbl[i].esc_at, tbl[i].exp_iter, tbl[i].exp_esc, 0);
        end
        run_frame(4, 0, 4, 0, 2);
        for (int i = 0; i < 4; i++) begin
            run_frame(int'($urandom_range(0, 6)), -1, 0, 0, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
